// File: rtl/fwtimer_pkg.sv
// Shared constants for the fwtimer_wb Wishbone timer block:
// register offsets, CTRL bit positions, prescaler width, ack FSM states.
package fwtimer_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_AUTO    = 1;
   localparam int CTRL_IE      = 2;
   localparam int CTRL_PRE_LSB = 8;
   localparam int PRE_W        = 8;

   localparam int CH_W = 3;

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } ack_state_e;

endpackage

// File: rtl/fwtimer_chan.sv
// One timer channel: CTRL/LOAD/COUNT/STATUS, prescaler, down-counter.
// Ports: decoded write strobes + wdata in; register readback + irq out.
import fwtimer_pkg::*;

module fwtimer_chan (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_ctrl,
   input  logic        wr_load,
   input  logic        wr_status,
   input  logic [31:0] wdata,
   input  logic [1:0]  rsel,
   output logic [31:0] rdata,
   output logic        irq
);

   logic             en_q, en_d;
   logic             auto_q, auto_d;
   logic             ie_q, ie_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] pcnt_q, pcnt_d;
   logic [31:0]      load_q, load_d;
   logic [31:0]      count_q, count_d;
   logic             pend_q, pend_d;

   logic tick;
   logic expire;

   // >= keeps ticking sane if PRE shrinks while running
   assign tick   = en_q && (pcnt_q >= pre_q);
   assign expire = tick && (count_q == 32'd0);

   always_comb begin
      en_d    = en_q;
      auto_d  = auto_q;
      ie_d    = ie_q;
      pre_d   = pre_q;
      load_d  = load_q;
      count_d = count_q;
      pend_d  = pend_q;

      if (!en_q || tick) pcnt_d = '0;
      else               pcnt_d = pcnt_q + 8'd1;

      if (tick) begin
         if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
         end else begin
            pend_d = 1'b1;
            if (auto_q) count_d = load_q;
            else        en_d    = 1'b0;
         end
      end

      if (wr_ctrl) begin
         en_d   = wdata[CTRL_EN];
         auto_d = wdata[CTRL_AUTO];
         ie_d   = wdata[CTRL_IE];
         pre_d  = wdata[CTRL_PRE_LSB +: PRE_W];
         // a one-shot expiring this cycle counts as stopped: restart it
         if (wdata[CTRL_EN] &&
             (!en_q || (expire && !auto_q))) begin
            count_d = load_q;
            pcnt_d  = '0;
         end
      end

      if (wr_load) begin
         load_d = wdata;
         if (!en_q) count_d = wdata;
      end

      // expiry in the same cycle beats the clear
      if (wr_status && wdata[0] && !expire)
         pend_d = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         en_q    <= 1'b0;
         auto_q  <= 1'b0;
         ie_q    <= 1'b0;
         pre_q   <= '0;
         pcnt_q  <= '0;
         load_q  <= '0;
         count_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         en_q    <= en_d;
         auto_q  <= auto_d;
         ie_q    <= ie_d;
         pre_q   <= pre_d;
         pcnt_q  <= pcnt_d;
         load_q  <= load_d;
         count_q <= count_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (rsel)
         REG_CTRL:   rdata = {16'd0, pre_q, 5'd0,
                              ie_q, auto_q, en_q};
         REG_LOAD:   rdata = load_q;
         REG_COUNT:  rdata = count_q;
         REG_STATUS: rdata = {31'd0, pend_q};
         default:    rdata = '0;
      endcase
   end

   assign irq = pend_q & ie_q;

endmodule

// File: rtl/fwtimer_wb.sv
// Wishbone-attached multi-channel down-counting timer (top).
// Ports: clock/reset, WB target rt_*, per-channel level irq[N_TIMER].
import fwtimer_pkg::*;

module fwtimer_wb #(
   parameter int N_TIMER = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [31:0]        rt_adr,
   input  logic [31:0]        rt_dat_w,
   output logic [31:0]        rt_dat_r,
   input  logic               rt_cyc,
   input  logic               rt_stb,
   input  logic [3:0]         rt_sel,
   input  logic               rt_we,
   output logic               rt_ack,
   output logic               rt_err,
   output logic [N_TIMER-1:0] irq
);

   ack_state_e  state_q;
   logic        ack_q;
   logic [31:0] dat_q;
   logic [31:0] dat_d;

   logic [CH_W-1:0] chan;
   logic [1:0]      rsel;
   logic            req;
   logic            wr;
   logic [31:0]     ch_rdata [N_TIMER];

   logic unused_bits;
   assign unused_bits = ^{rt_sel, rt_adr[31:7], rt_adr[1:0]};

   assign chan = rt_adr[6:4];
   assign rsel = rt_adr[3:2];
   assign req  = rt_cyc && rt_stb && (state_q == ST_IDLE);
   assign wr   = req && rt_we;

   for (genvar i = 0; i < N_TIMER; i++) begin : g_ch
      logic hit;
      assign hit = wr && (chan == 3'(i));

      fwtimer_chan u_chan (
         .clock     (clock),
         .reset     (reset),
         .wr_ctrl   (hit && (rsel == REG_CTRL)),
         .wr_load   (hit && (rsel == REG_LOAD)),
         .wr_status (hit && (rsel == REG_STATUS)),
         .wdata     (rt_dat_w),
         .rsel      (rsel),
         .rdata     (ch_rdata[i]),
         .irq       (irq[i])
      );
   end

   // unmapped channels fall through to zero
   always_comb begin
      dat_d = '0;
      for (int i = 0; i < N_TIMER; i++)
         if (!rt_we && chan == 3'(i))
            dat_d = ch_rdata[i];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rt_cyc && rt_stb) begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= dat_d;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
            default: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
         endcase
      end
   end

   assign rt_ack   = ack_q;
   assign rt_dat_r = dat_q;
   assign rt_err   = 1'b0;

endmodule

// File: tb/tb_fwtimer_wb.sv
// Directed self-checking bench for fwtimer_wb (N_TIMER=2).
// All stimulus is driven 1ns after the rising clock edge.
module tb_fwtimer_wb;

   logic        clock;
   logic        reset;
   logic [31:0] rt_adr;
   logic [31:0] rt_dat_w;
   logic [31:0] rt_dat_r;
   logic        rt_cyc;
   logic        rt_stb;
   logic [3:0]  rt_sel;
   logic        rt_we;
   logic        rt_ack;
   logic        rt_err;
   logic [1:0]  irq;

   int n_checks = 0;
   int n_err    = 0;

   fwtimer_wb #(.N_TIMER(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .rt_adr   (rt_adr),
      .rt_dat_w (rt_dat_w),
      .rt_dat_r (rt_dat_r),
      .rt_cyc   (rt_cyc),
      .rt_stb   (rt_stb),
      .rt_sel   (rt_sel),
      .rt_we    (rt_we),
      .rt_ack   (rt_ack),
      .rt_err   (rt_err),
      .irq      (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic xfer(input logic we,
                       input logic [31:0] adr,
                       input logic [31:0] wd,
                       output logic [31:0] rd);
      int n;
      rt_cyc   = 1'b1;
      rt_stb   = 1'b1;
      rt_we    = we;
      rt_adr   = adr;
      rt_dat_w = wd;
      rt_sel   = 4'hf;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!rt_ack && n < 4);
      if (!rt_ack) begin
         n_checks++;
         n_err++;
         $display("FAIL bus_timeout adr=%h ack=%b required 1",
                  adr, rt_ack);
      end
      rd     = rt_dat_r;
      rt_cyc = 1'b0;
      rt_stb = 1'b0;
      rt_we  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] adr,
                     input logic [31:0] d);
      logic [31:0] junk;
      xfer(1'b1, adr, d, junk);
   endtask

   task automatic rd(input logic [31:0] adr,
                     output logic [31:0] d);
      xfer(1'b0, adr, 32'd0, d);
   endtask

   // edges until irq[idx] goes high, capped at 40
   task automatic wait_irq(input int idx, output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!irq[idx] && n < 40);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      n_checks++;
      if (irq !== 2'b00 || rt_ack !== 1'b0 ||
          rt_dat_r !== 32'd0 || rt_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out irq=%b ack=%b dat=%h err=%b required 0",
                  irq, rt_ack, rt_dat_r, rt_err);
      end
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < 4; r++) begin
            rd(32'(c * 16 + r * 4), d);
            n_checks++;
            if (d !== 32'd0) begin
               n_err++;
               $display("FAIL reset_reg ch=%0d reg=%0d got %h required 0",
                        c, r, d);
            end
         end
      end
   endtask

   task automatic test_periodic;
      logic [31:0] d;
      logic [31:0] exp_cnt [5];
      int n;
      wr(32'h04, 32'd4);
      wr(32'h00, 32'h7);
      wait_irq(0, n);
      n_checks++;
      if (n !== 5) begin
         n_err++;
         $display("FAIL periodic_first got %0d clocks required 5", n);
      end
      wr(32'h0C, 32'd1);
      n_checks++;
      if (irq[0] !== 1'b0) begin
         n_err++;
         $display("FAIL periodic_w1c irq0=%b required 0", irq[0]);
      end
      // W1C landed 1 edge after expiry; next expiry 4 edges later
      wait_irq(0, n);
      n_checks++;
      if (n !== 4) begin
         n_err++;
         $display("FAIL periodic_second got %0d clocks required 4", n);
      end
      wr(32'h00, 32'h0);
      wr(32'h0C, 32'd1);
      wr(32'h00, 32'h7);
      // reads land on edges 2,4,6,8,10 after enable and
      // return COUNT after edges 1,3,5,7,9: 4-k mod 5
      exp_cnt[0] = 32'd3;
      exp_cnt[1] = 32'd1;
      exp_cnt[2] = 32'd4;
      exp_cnt[3] = 32'd2;
      exp_cnt[4] = 32'd0;
      for (int k = 0; k < 5; k++) begin
         rd(32'h08, d);
         n_checks++;
         if (d !== exp_cnt[k]) begin
            n_err++;
            $display("FAIL periodic_count idx=%0d got %0d required %0d",
                     k, d, exp_cnt[k]);
         end
         if (k == 2) begin
            n_checks++;
            if (irq[0] !== 1'b1) begin
               n_err++;
               $display("FAIL periodic_irq irq0=%b required 1", irq[0]);
            end
         end
      end
      wr(32'h00, 32'h0);
      wr(32'h0C, 32'd1);
      n_checks++;
      if (irq[0] !== 1'b0) begin
         n_err++;
         $display("FAIL periodic_cleanup irq0=%b required 0", irq[0]);
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] d;
      int n;
      wr(32'h14, 32'd2);
      wr(32'h10, 32'h305);
      wait_irq(1, n);
      n_checks++;
      if (n !== 12) begin
         n_err++;
         $display("FAIL oneshot_time got %0d clocks required 12", n);
      end
      rd(32'h10, d);
      n_checks++;
      if (d !== 32'h304) begin
         n_err++;
         $display("FAIL oneshot_ctrl got %h required 00000304", d);
      end
      rd(32'h1C, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_err++;
         $display("FAIL oneshot_pend got %h required 1", d);
      end
      wr(32'h1C, 32'd1);
      repeat (30) @(posedge clock);
      #1;
      rd(32'h1C, d);
      n_checks++;
      if (d !== 32'd0 || irq[1] !== 1'b0) begin
         n_err++;
         $display("FAIL oneshot_quiet status=%h irq1=%b required 0,0",
                  d, irq[1]);
      end
      wr(32'h18, 32'h55);
      rd(32'h18, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_err++;
         $display("FAIL count_ro got %h required 0", d);
      end
   endtask

   task automatic test_w1c_race;
      logic [31:0] d;
      wr(32'h04, 32'd4);
      wr(32'h00, 32'h7);
      // expiry on edge 5 after enable; W1C is sampled on edge 5
      repeat (4) @(posedge clock);
      #1;
      wr(32'h0C, 32'd1);
      n_checks++;
      if (irq[0] !== 1'b1) begin
         n_err++;
         $display("FAIL race_irq irq0=%b required 1", irq[0]);
      end
      rd(32'h0C, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_err++;
         $display("FAIL race_pend got %h required 1", d);
      end
      wr(32'h00, 32'h0);
      wr(32'h0C, 32'd1);
   endtask

   task automatic test_ie_mask;
      logic [31:0] d;
      wr(32'h14, 32'd1);
      wr(32'h10, 32'h1);
      repeat (10) @(posedge clock);
      #1;
      n_checks++;
      if (irq[1] !== 1'b0) begin
         n_err++;
         $display("FAIL mask_irq irq1=%b required 0", irq[1]);
      end
      rd(32'h1C, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_err++;
         $display("FAIL mask_pend got %h required 1", d);
      end
      wr(32'h10, 32'h4);
      n_checks++;
      if (irq[1] !== 1'b1) begin
         n_err++;
         $display("FAIL unmask_irq irq1=%b required 1", irq[1]);
      end
      wr(32'h10, 32'h0);
      rd(32'h1C, d);
      n_checks++;
      if (irq[1] !== 1'b0 || d !== 32'd1) begin
         n_err++;
         $display("FAIL remask irq1=%b status=%h required 0,1",
                  irq[1], d);
      end
      wr(32'h1C, 32'd1);
      rd(32'h1C, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_err++;
         $display("FAIL mask_clear got %h required 0", d);
      end
   endtask

   task automatic test_unmapped;
      logic [31:0] d;
      logic        a [3];
      wr(32'h04, 32'h1234);
      wr(32'h24, 32'hdead);
      rd(32'h20, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_err++;
         $display("FAIL unmapped_rd got %h required 0", d);
      end
      rd(32'h24, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_err++;
         $display("FAIL unmapped_wr got %h required 0", d);
      end
      rd(32'h04, d);
      n_checks++;
      if (d !== 32'h1234) begin
         n_err++;
         $display("FAIL ch0_load got %h required 00001234", d);
      end
      @(posedge clock);
      #1;
      rt_cyc = 1'b1;
      rt_stb = 1'b1;
      rt_we  = 1'b0;
      rt_adr = 32'h20;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         a[k] = rt_ack;
      end
      rt_cyc = 1'b0;
      rt_stb = 1'b0;
      n_checks++;
      if (a[0] !== 1'b1 || a[1] !== 1'b0 || a[2] !== 1'b1) begin
         n_err++;
         $display("FAIL held_ack got %b%b%b required 101",
                  a[0], a[1], a[2]);
      end
      n_checks++;
      if (rt_err !== 1'b0) begin
         n_err++;
         $display("FAIL err_tie got %b required 0", rt_err);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(32'h14, 32'h99);
      @(posedge clock);
      #1;
      rt_cyc = 1'b1;
      rt_stb = 1'b1;
      rt_we  = 1'b0;
      rt_adr = 32'h14;
      @(posedge clock);
      #1;
      n_checks++;
      if (rt_ack !== 1'b1 || rt_dat_r !== 32'h99) begin
         n_err++;
         $display("FAIL mid_pre ack=%b dat=%h required 1,00000099",
                  rt_ack, rt_dat_r);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (rt_ack !== 1'b0 || rt_dat_r !== 32'd0) begin
         n_err++;
         $display("FAIL mid_reset ack=%b dat=%h required 0,0",
                  rt_ack, rt_dat_r);
      end
      rt_cyc = 1'b0;
      rt_stb = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      rd(32'h14, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_err++;
         $display("FAIL mid_cleared got %h required 0", d);
      end
   endtask

   initial begin
      reset    = 1'b1;
      rt_adr   = '0;
      rt_dat_w = '0;
      rt_cyc   = 1'b0;
      rt_stb   = 1'b0;
      rt_sel   = 4'hf;
      rt_we    = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      test_reset;
      test_periodic;
      test_oneshot;
      test_w1c_race;
      test_ie_mask;
      test_unmapped;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_err);
      $finish;
   end

endmodule
